// File: rtl/reg_dump_pkg.sv
// Shared types and sizing for the register dump path.
// REG_DUMP_HEADER_EN adds one address header byte in front of every register.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

`ifdef REG_DUMP_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  // Byte counter width for a frame of nbytes bytes (never narrower than 1 bit).
  function automatic int cnt_width(input int nbytes);
    if (nbytes > 1) begin
      return $clog2(nbytes);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Loads a frame in parallel and emits it MSB byte first over valid/ready.
// The byte and valid stay frozen while the consumer stalls.
module word_byte_serializer
  import reg_dump_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD + HDR_BYTES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [NBYTES*8-1:0] word,
  input  logic                ready,
  output logic                valid,
  output logic [7:0]          data,
  output logic                last,
  output logic                fire
);

  localparam int W  = NBYTES * 8;
  localparam int CW = cnt_width(NBYTES);

  logic [W-1:0]  shreg;
  logic [CW-1:0] byte_cnt;

  assign data = shreg[W-1 -: 8];
  assign last = (byte_cnt == CW'(NBYTES - 1));
  assign fire = valid && ready;

  // Valid drops on the last accepted byte so the FSM can reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= '0;
      valid    <= 1'b1;
    end else if (fire) begin
      shreg    <= shreg << 8;
      byte_cnt <= byte_cnt + CW'(1);
      if (last) begin
        valid <= 1'b0;
      end else begin
        valid <= 1'b1;
      end
    end else begin
      shreg    <= shreg;
      byte_cnt <= byte_cnt;
      valid    <= valid;
    end
  end

endmodule

// File: rtl/reg_dump_ctrl.sv
// Walks the register file through a spare read port and streams each word to UART TX.
// REG_DUMP_HEADER_EN prefixes each word with its zero-extended register address.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int NBYTES = DATA_WIDTH / 8 + HDR_BYTES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t state, next_state;
  logic [NBYTES*8-1:0] load_word;
  logic load, fire, last, word_done, at_last_addr;

`ifdef REG_DUMP_HEADER_EN
  assign load_word = {8'(rf_addr), rf_data};
`else
  assign load_word = rf_data;
`endif

  assign at_last_addr = (rf_addr == LAST_ADDR);
  assign word_done    = fire && last;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LATCH;
        end else begin
          next_state = IDLE;
        end
      end
      LATCH: begin
        load       = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        if (word_done) begin
          if (at_last_addr) begin
            next_state = DONE;
          end else begin
            next_state = LATCH;
          end
        end else begin
          next_state = SEND;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are registered from next_state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rf_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == LATCH) || (next_state == SEND);
      done  <= (next_state == DONE);
      if ((state == SEND) && word_done && !at_last_addr) begin
        rf_addr <= rf_addr + ADDR_WIDTH'(1);
      end else if (state == DONE) begin
        rf_addr <= '0;
      end else begin
        rf_addr <= rf_addr;
      end
    end
  end

  word_byte_serializer #(
    .NBYTES(NBYTES)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .word (load_word),
    .ready(tx_ready),
    .valid(tx_valid),
    .data (tx_data),
    .last (last),
    .fire (fire)
  );

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl; honours REG_DUMP_HEADER_EN like the RTL.
module tb_reg_dump_ctrl;

`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BPR      = 4 + HDR;
  localparam int P        = 1 + BPR;
  localparam int DONE_CYC = 1 + 32 * P;

  logic        clk = 1'b0;
  logic        reset, start, tx_ready;
  logic        busy, done, tx_valid;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [7:0]  tx_data;

  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;
  int done_cnt, done_cyc, busy_first, busy_last;
  logic monitor_on = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  reg_dump_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    if (monitor_on) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - base;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = cyc - base;
        busy_last = cyc - base;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      if (HDR == 1) exp_q.push_back(8'(r));
      for (int b = 3; b >= 0; b--) exp_q.push_back(rf[r][b*8 +: 8]);
    end
  endtask

  task automatic run_dump(input int restart_at, input int stall_at, input int stall_len,
                          input int wr_at, input int reset_at, input int max_k);
    got_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    busy_first = -1;
    busy_last  = -1;
    @(posedge clk); #1;
    base       = cyc;
    monitor_on = 1'b1;
    for (int k = 0; k < max_k; k++) begin
      start    = (k == 0) || (k == restart_at);
      tx_ready = !((stall_at >= 0) && (k >= stall_at) && (k < stall_at + stall_len)) &&
                 (k != reset_at);
      wr_en    = (k == wr_at);
      reset    = (k == reset_at);
      if ((stall_at >= 0) && (k >= stall_at) && (k <= stall_at + stall_len)) begin
        check("stall_data", 32'(tx_data), 32'h11);
        check("stall_valid", 32'(tx_valid), 32'h1);
      end
      if (k == wr_at) check("wr_latch_addr", 32'(rf_addr), 32'd5);
      @(posedge clk); #1;
      if (k == reset_at) begin
        check("rst_valid", 32'(tx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_addr", 32'(rf_addr), 32'h0);
        check("rst_data", 32'(tx_data), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        break;
      end
      if ((done_cyc >= 0) && ((cyc - base) > done_cyc + 3)) break;
    end
    start      = 1'b0;
    tx_ready   = 1'b1;
    wr_en      = 1'b0;
    reset      = 1'b0;
    monitor_on = 1'b0;
  endtask

  task automatic compare_run(input string tag, input int exp_done);
    int n;
    check({tag, "_bytes"}, 32'(got_q.size()), 32'(32 * BPR));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    vectors++;
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_first"}, 32'(busy_first), 32'd1);
    check({tag, "_busy_last"}, 32'(busy_last), 32'(exp_done - 1));
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = 5'd5;
    wr_data  = 32'hCAFE_F00D;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1]  = 32'h1122_3344;
    rf[31] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(tx_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_addr", 32'(rf_addr), 32'h0);
    check("reset_data", 32'(tx_data), 32'h0);
    reset = 1'b0;

    // Plain full dump with the consumer always ready.
    build_expected();
    run_dump(-1, -1, 0, -1, -1, 400);
    compare_run("full", DONE_CYC);
    check("full_x1_first", 32'(got_q[BPR + HDR]), 32'h11);
    check("full_x1_hdr", 32'(got_q[BPR]), (HDR == 1) ? 32'h01 : 32'h11);
    check("full_last", 32'(got_q[32 * BPR - 1]), 32'hEF);

    run_dump(50, -1, 0, -1, -1, 400);
    compare_run("restart", DONE_CYC);

    run_dump(-1, 7 + 2 * HDR, 3, -1, -1, 400);
    compare_run("stall", DONE_CYC + 3);

    // Core write to x5 in its LATCH cycle: old value first, new value next time.
    run_dump(-1, -1, 0, 1 + 5 * P, -1, 400);
    compare_run("wr_old", DONE_CYC);
    check("wr_old_x5", 32'(got_q[5 * BPR + HDR]), 32'h00);
    build_expected();
    run_dump(-1, -1, 0, -1, -1, 400);
    compare_run("wr_new", DONE_CYC);
    check("wr_new_x5", 32'(got_q[5 * BPR + HDR]), 32'hCA);

    run_dump(-1, -1, 0, -1, 7 * P + 3 + HDR, 400);
    check("rst_partial_bytes", 32'(got_q.size()), 32'(7 * BPR + 1 + HDR));
    run_dump(-1, -1, 0, -1, -1, 400);
    compare_run("after_rst", DONE_CYC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
Debug read-out stage downstream of the register file. On a `start` pulse it walks every architectural register through a dedicated asynchronous read port (`rf_addr` / `rf_data`). It snapshots each 32-bit value and streams it as bytes over a valid/ready handshake into the UART TX block. This gives the single-cycle core a register dump over the serial link without halting writes.

Parameters:
- DATA_WIDTH, 32, register width; must be a multiple of 8.
- ADDR_WIDTH, 5, register address width; registers dumped = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse after the last byte of the last register is accepted.
- rf_addr  output  ADDR_WIDTH  register file read address; drives a spare read port.
- rf_data  input  DATA_WIDTH  asynchronous read data for rf_addr.
- tx_data  output  8  byte to UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX accepts the byte this cycle.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, rf_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, shift register=0, byte count=0.
- States: IDLE, LATCH, SEND, DONE.
- IDLE -> LATCH when start=1.
- LATCH (1 cycle):
  - shreg <= rf_data at current rf_addr; byte_cnt <= 0.
  - If a core write hits the same address this cycle, the pre-write value is captured.
  - -> SEND.
- SEND:
  - tx_valid=1; tx_data = shreg[DATA_WIDTH-1 -: 8], so the MSB byte goes first.
  - A byte transfers only when tx_valid && tx_ready. On transfer: shreg <<= 8; byte_cnt++.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - On transfer of byte DATA_WIDTH/8-1:
    - if rf_addr == 2**ADDR_WIDTH-1 -> DONE;
    - else rf_addr++ and -> LATCH.
- DONE (1 cycle): done=1, tx_valid=0, rf_addr <= 0; -> IDLE.
- busy=1 in LATCH and SEND; 0 in IDLE and DONE.
- start while busy or in DONE: ignored, with no queuing.
- Latency: start at cycle 0 -> LATCH at cycle 1 -> first tx_valid at cycle 2.
- With tx_ready held at 1, each register costs 1+DATA_WIDTH/8 cycles. For 32 regs: busy on cycles 1..160, done at cycle 161, 128 bytes total.
- Reset mid-dump: next cycle is IDLE with all outputs at reset values. A byte offered but not accepted is dropped, with no partial-word recovery.
- rf_addr wraps only through DONE; it never increments past 2**ADDR_WIDTH-1.

Optional Feature:
- Macro: REG_DUMP_HEADER_EN.
- Defined: each register is preceded by one header byte, zero-extended {(8-ADDR_WIDTH)'b0, rf_addr}, sent in SEND before the data bytes.
  - byte_cnt spans 0..DATA_WIDTH/8.
  - Per-register cost is 2+DATA_WIDTH/8 cycles; 160 bytes per full dump.
- Undefined: data bytes only, as described above.

Decomposition:
- Package reg_dump_pkg:
  - state enum (IDLE, LATCH, SEND, DONE);
  - BYTES_PER_WORD = DATA_WIDTH/8;
  - HDR_BYTES (0 or 1 depending on REG_DUMP_HEADER_EN);
  - byte counter width.
- One natural sub-module, word_byte_serializer: parallel load, MSB-first shift, valid/ready hold, and a last-byte flag. The FSM and address counter stay in reg_dump_ctrl.

Test Plan:
- Full dump, tx_ready=1, x1=0x11223344, x31=0xDEADBEEF, others zero:
  - byte stream is 4 zero bytes, then 11 22 33 44, …, ending DE AD BE EF;
  - 128 bytes total; done pulse at cycle 161; busy high on cycles 1..160.
- Backpressure on x1's first byte, tx_ready=0 for 3 cycles:
  - tx_data=0x11 and tx_valid=1 stay stable for all 3 cycles;
  - the byte is accepted once, on the 4th cycle;
  - no duplicate or lost bytes.
- start pulsed again at cycle 50 during a dump: ignored; stream identical to the single-dump case; exactly one done.
- Core writes x5=0xCAFEF00D in the same cycle as LATCH for x5: the old x5 value is dumped; a second dump shows 0xCAFEF00D.
- reset asserted in SEND for x7 (second byte pending):
  - the following cycle has tx_valid=0, busy=0, rf_addr=0;
  - a new start restarts from x0.
- REG_DUMP_HEADER_EN defined, x1=0x11223344: bytes for x1 are 01 11 22 33 44; 160 bytes total; done at cycle 193.
